// File: rtl/lcd1602_arb.sv
// lcd1602_arb -- two-requester arbiter in front of a shared LCD1602
// byte-write engine.
//
// Each requester raises iCallN with a register select and a data byte. The
// arbiter grants one requester, latches its byte, and drives the engine
// until iDone. It then pulses oDoneN to the granted requester and spends one
// RELEASE cycle before it samples requests again. When both requesters ask
// at once, the grant alternates between them (round-robin).
//
// Optional feature: define LCD1602_ARB_TIMEOUT_EN to enable a BUSY watchdog.
// After TIMEOUT_CYC cycles without iDone, the transfer is aborted with oErr.
// Without the macro, BUSY waits indefinitely and oErr is tied low.
//
// Ports
//   CLOCK         in   system clock, rising edge
//   RST_n         in   asynchronous active-low reset
//   iCall0/1      in   write request, held until oDoneN
//   iRS0/1        in   register select (0 instruction, 1 data)
//   iDATA0/1[7:0] in   byte to write
//   oDone0/1      out  one-cycle completion pulse per requester
//   oCall         out  request to the byte-write engine
//   oRS           out  latched register select
//   oDATA[7:0]    out  latched byte
//   iDone         in   engine completion pulse
//   oBusy         out  arbiter is not in IDLE
//   oErr          out  one-cycle watchdog-abort pulse
//
// state   | meaning
// IDLE    | waiting for a request; the grant is decided here
// BUSY    | oCall held, waiting for iDone (or the watchdog)
// RELEASE | oDoneN is high; requests are ignored for this one cycle
module lcd1602_arb #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       iCall0,
  input  logic       iRS0,
  input  logic [7:0] iDATA0,
  output logic       oDone0,
  input  logic       iCall1,
  input  logic       iRS1,
  input  logic [7:0] iDATA1,
  output logic       oDone1,
  output logic       oCall,
  output logic       oRS,
  output logic [7:0] oDATA,
  input  logic       iDone,
  output logic       oBusy,
  output logic       oErr
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t     state, state_nx;
  logic       grant, grant_nx;          // requester currently being served
  logic       last_grant, last_grant_nx;
  logic       call_nx, rs_nx, done0_nx, done1_nx, err_nx;
  logic [7:0] data_nx;
  logic       pick;
  logic       tmo_hit;

`ifdef LCD1602_ARB_TIMEOUT_EN
  logic [19:0] tmo_cnt, tmo_cnt_nx;
  assign tmo_hit = (tmo_cnt == TIMEOUT_CYC);
`else
  assign tmo_hit = 1'b0;
  wire unused_timeout = ^TIMEOUT_CYC;
`endif

  assign oBusy = (state != IDLE);

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      oCall      <= 1'b0;
      oRS        <= 1'b0;
      oDATA      <= 8'h00;
      oDone0     <= 1'b0;
      oDone1     <= 1'b0;
      oErr       <= 1'b0;
`ifdef LCD1602_ARB_TIMEOUT_EN
      tmo_cnt    <= 20'd0;
`endif
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      oCall      <= call_nx;
      oRS        <= rs_nx;
      oDATA      <= data_nx;
      oDone0     <= done0_nx;
      oDone1     <= done1_nx;
      oErr       <= err_nx;
`ifdef LCD1602_ARB_TIMEOUT_EN
      tmo_cnt    <= tmo_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    call_nx       = oCall;
    rs_nx         = oRS;
    data_nx       = oDATA;
    done0_nx      = 1'b0;
    done1_nx      = 1'b0;
    err_nx        = 1'b0;
    pick          = 1'b0;
`ifdef LCD1602_ARB_TIMEOUT_EN
    tmo_cnt_nx    = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (iCall0 || iCall1) begin
          // On a tie, grant the requester that was not served last time.
          // A lone requester wins regardless of history.
          pick          = (iCall0 && iCall1) ? ~last_grant : iCall1;
          grant_nx      = pick;
          last_grant_nx = pick;
          rs_nx         = pick ? iRS1 : iRS0;
          data_nx       = pick ? iDATA1 : iDATA0;
          call_nx       = 1'b1;
          state_nx      = BUSY;
`ifdef LCD1602_ARB_TIMEOUT_EN
          tmo_cnt_nx    = 20'd0;
`endif
        end
      end
      BUSY: begin
        if (iDone || tmo_hit) begin
          // A real completion takes priority over a watchdog abort
          // that lands in the same cycle.
          call_nx  = 1'b0;
          done0_nx = ~grant;
          done1_nx = grant;
          err_nx   = ~iDone & tmo_hit;
          state_nx = RELEASE;
        end else begin
`ifdef LCD1602_ARB_TIMEOUT_EN
          tmo_cnt_nx = tmo_cnt + 20'd1;
`endif
        end
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/lcd1602_arb.md
LCD1602_ARB -- requirements
Module: lcd1602_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20'd1000000, is the maximum number of cycles in BUSY before a watchdog abort (used only with LCD1602_ARB_TIMEOUT_EN).
REQ-002 CLOCK  input  1  system clock; all logic on its rising edge.
REQ-003 RST_n  input  1  asynchronous, active-low reset.
REQ-004 iCall0  input  1  requester 0 write request; held high until oDone0 is seen.
REQ-005 iRS0  input  1  requester 0 register select (0 = instruction, 1 = data).
REQ-006 iDATA0  input  8  requester 0 byte; stable while iCall0 is high.
REQ-007 oDone0  output  1  one-cycle completion pulse to requester 0.
REQ-008 iCall1, iRS1, iDATA1[7:0], oDone1: same as REQ-004..007, for requester 1.
REQ-009 oCall  output  1  request to the shared LCD1602 byte-write engine.
REQ-010 oRS  output  1  latched register select to the engine.
REQ-011 oDATA  output  8  latched byte to the engine.
REQ-012 iDone  input  1  engine completion pulse.
REQ-013 oBusy  output  1  high in any state other than IDLE.
REQ-014 oErr  output  1  one-cycle watchdog-abort pulse.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and RELEASE.
REQ-016 IDLE: if any iCallN is high, latch the winner's iRS/iDATA into oRS/oDATA, record the grant, and go to BUSY; oCall rises on the next cycle (1-cycle request latency).
REQ-017 Tie-break (both requests high in IDLE) SHALL be round-robin: grant the requester not granted last; a single requester is granted regardless of history.
REQ-018 BUSY: oCall SHALL be held high and oRS/oDATA held constant until iDone is sampled high.
REQ-019 On iDone high in BUSY: next cycle oCall=0, oDoneN=1 for the granted requester only, state goes to RELEASE.
REQ-020 RELEASE: a single cycle, then IDLE; requests are not sampled in RELEASE, so a requester dropping iCall after oDone cannot be granted twice.
REQ-021 Minimum request-to-request spacing SHALL be 3 cycles plus engine time; back-to-back requests from one requester are legal.
REQ-022 iDone outside BUSY SHALL be ignored.
REQ-023 A requester dropping iCall while granted SHALL NOT abort the transfer; it completes and oDone still pulses.
REQ-024 oDone0 and oDone1 SHALL never be high in the same cycle.

Reset
REQ-025 On RST_n low (asynchronous, any state, including mid-BUSY): state=IDLE, oCall=0, oRS=0, oDATA=8'h00, oDone0=oDone1=0, oErr=0, oBusy=0, last grant=1 (requester 0 wins the first tie), timeout counter=0.
REQ-026 An interrupted transfer SHALL NOT produce oDone after reset release.

Configuration
REQ-027 With macro LCD1602_ARB_TIMEOUT_EN defined, a counter cleared on BUSY entry increments each BUSY cycle. On reaching TIMEOUT_CYC without iDone, the next cycle gives oCall=0, oErr=1 for one cycle, and oDoneN=1 for the granted requester, then RELEASE.
REQ-028 With LCD1602_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; oErr is tied to 0.

Verification
REQ-029 Reset, then iCall0=1, iRS0=0, iDATA0=8'h38; engine returns iDone 5 cycles after oCall -> oCall high at cycle 1 with oRS=0, oDATA=8'h38; oDone0 one pulse; oDone1 never.
REQ-030 iCall0 and iCall1 rise on the same cycle after reset, iDATA0=8'h80, iDATA1=8'hC0, both re-requesting after done -> grants alternate 0,1,0,1 and oDATA alternates 8'h80/8'hC0.
REQ-031 Only requester 1 requests, 4 bytes back-to-back (8'h41..8'h44) -> all 4 granted in order, each with its own oDone1 pulse; oDone0 stays 0.
REQ-032 RST_n pulsed low 3 cycles into BUSY -> oCall drops asynchronously; no oDone after release; next request is served normally.
REQ-033 LCD1602_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, iDone held 0 -> oErr and oDone0 pulse 17 cycles after BUSY entry; oCall low from then on. Macro undefined -> oCall stays high, oErr stays 0.
